atm_session_fsm: RTL
====================

# atm_session_fsm

Parametrised ATM session controller: sequences one customer session from card insertion through PIN check, mode selection, amount entry, biometric/OTP authentication, cash-mechanism execution, receipt and card return. Next-generation controller for the ATM front panel, adding PIN retry limit with card retention, per-state inactivity timeout, user cancel, balance check and amount-dependent OTP. Sits between the panel/keypad/biometric inputs and the cash mechanism, printer and card reader actuators.

## Interface
- `AMT_W`, 16: width of requested amount.
- `BAL_W`, 24: width of account balance; must be ≥ `AMT_W`.
- `MAX_PIN_TRIES`, 3: failed PINs allowed before the card is retained; must be ≥ 1.
- `TIMEOUT_CYC`, 1000: inactivity limit per timed state, in cycles; must be ≥ 2.
- `OTP_THRESHOLD`, 5000: a withdrawal with amount ≥ this value requires OTP.

Ports:
- `clk` in 1: single clock; all logic rises on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `card_inserted` in 1: level, card present in reader.
- `card_valid` / `card_invalid` in 1: one-cycle scan result pulses.
- `pin_valid` / `pin_invalid` in 1: one-cycle PIN result pulses.
- `mode_valid` in 1, `mode_sel` in 2: mode strobe; 0 withdraw, 1 deposit, 2 balance, 3 illegal.
- `amount_valid` in 1, `amount` in AMT_W: amount strobe.
- `balance_in` in BAL_W: account balance, stable while in AMOUNT.
- `face_ok` / `face_fail` in 1: biometric result pulses.
- `otp_ok` / `otp_fail` in 1: OTP result pulses.
- `hw_done` in 1: pulse from the cash mechanism or printer when the current action is finished.
- `cancel` in 1: user cancel pulse.
- `dispense_cash`, `deposit_cash`, `print_receipt`, `capture_face`, `prompt_otp` out 1: registered action levels.
- `eject_card`, `retain_card` out 1: one-cycle actuator pulses.
- `txn_amount` out AMT_W: latched accepted amount.
- `display_message` out 8: status code.

## Operation
- States and `display_message` codes: IDLE 0x00, SCAN 0x01, PIN 0x02, MODE 0x03, AMOUNT 0x04, FACE 0x05, OTP 0x06, EXEC 0x07, RECEIPT 0x08, EJECT (shows latched `err_code`, 0x09 if none), RETAIN 0xE3.
- Error codes:
  - 0xE1: insufficient funds.
  - 0xE2: timeout.
  - 0xE4: invalid card.
  - 0xE5: authentication fail.
  - 0xE6: cancelled.
- IDLE→SCAN on `card_inserted`=1.
- SCAN:
  - `card_valid`→PIN.
  - `card_invalid`→EJECT with 0xE4.
- PIN:
  - `pin_valid`→MODE.
  - `pin_invalid` increments `pin_fail_cnt`. Reaching MAX_PIN_TRIES→RETAIN; otherwise the FSM stays in PIN.
- MODE on `mode_valid`:
  - mode 0 or 1→AMOUNT.
  - mode 2→RECEIPT.
  - mode 3 is ignored and the FSM stays in MODE.
- AMOUNT on `amount_valid`:
  - `amount`=0 is ignored.
  - Withdraw with `amount` > `balance_in` (zero-extended compare)→EJECT with 0xE1.
  - Otherwise latch `txn_amount`. Withdraw→FACE; deposit→EXEC.
- FACE (`capture_face`=1):
  - `face_ok`→OTP if `txn_amount` ≥ OTP_THRESHOLD, else EXEC.
  - `face_fail`→EJECT with 0xE5.
- OTP (`prompt_otp`=1):
  - `otp_ok`→EXEC.
  - `otp_fail`→EJECT with 0xE5.
- EXEC: `dispense_cash` (withdraw) or `deposit_cash` (deposit) held at 1 until `hw_done`→RECEIPT.
- RECEIPT: `print_receipt`=1 until `hw_done`→EJECT with no error.
- EJECT: `eject_card` pulses on the entry cycle only. The FSM waits for `card_inserted`=0, then goes to IDLE and clears `err_code`, `pin_fail_cnt` and `txn_amount`.
- RETAIN: `retain_card` pulses on the entry cycle; next cycle→IDLE and counters clear.
- Timed states: SCAN, PIN, MODE, AMOUNT, FACE, OTP.
  - Timer clears on every state change and on every accepted or ignored strobe in the current state.
  - TIMEOUT_CYC consecutive cycles with no strobe→EJECT with 0xE2.
- `cancel` in a timed state→EJECT with 0xE6. `cancel` is ignored in IDLE, EXEC, RECEIPT, EJECT and RETAIN.
- Priority within one cycle: reset > cancel > timeout > result strobes.
- Simultaneous ok/fail pairs (for example `pin_valid`&`pin_invalid`) resolve as fail.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state IDLE.
  - all action outputs 0.
  - `txn_amount`=0, `display_message`=0x00.
  - counters 0, `err_code` cleared.
- Reset mid-session aborts immediately. No `eject_card` is generated.
- All outputs are Moore: registered from the state, valid the cycle after the transition edge. An input sampled at edge N gives the new state and outputs after edge N.
- Input strobes are sampled on one edge each. A level held for k cycles counts as k strobes (relevant for `pin_invalid`).
- Timer width is $clog2(TIMEOUT_CYC+1) bits. It saturates and never wraps.
- EXEC and RECEIPT have no timeout. They wait indefinitely for `hw_done`.

## Test plan
- **Full withdraw with OTP.** Card, `card_valid`, `pin_valid`, mode 0, amount 6000, balance 10000, `face_ok`, `otp_ok`, `hw_done` ×2. Required: `display_message` 0x01→…→0x07→0x08→0x09; `dispense_cash`=1 only in EXEC; `txn_amount`=6000; one `eject_card` pulse.
- **Deposit and balance inquiry.**
  - Mode 1, amount 200: FACE and OTP are skipped and `deposit_cash`=1.
  - Mode 2: MODE→RECEIPT directly.
- **PIN retry limit.** With MAX_PIN_TRIES=3, three `pin_invalid` pulses. Required: RETAIN with 0xE3, `retain_card` pulse, then IDLE. Two fails followed by `pin_valid` reaches MODE.
- **Insufficient funds and auth failure.**
  - Amount 500 with balance 499: EJECT with 0xE1, no `dispense_cash`.
  - `face_fail`: EJECT with 0xE5.
- **Timeout and cancel.** With TIMEOUT_CYC=20: idle in MODE for 20 cycles gives EJECT with 0xE2, and a strobe at cycle 19 restarts the timer. `cancel` together with `otp_ok` in OTP gives EJECT with 0xE6.
- **Reset mid-EXEC.** `reset` low during EXEC: all outputs 0 and state IDLE asynchronously, no eject pulse.

Source files
------------

// File: rtl/atm_session_fsm_if.sv
// Panel/actuator bundle for the ATM session controller: keypad, reader and
// biometric strobes in, cash/printer/reader actuator levels and status out.
interface atm_session_fsm_if #(
  parameter int AMT_W = 16,
  parameter int BAL_W = 24
);
  logic             card_inserted;
  logic             card_valid;
  logic             card_invalid;
  logic             pin_valid;
  logic             pin_invalid;
  logic             mode_valid;
  logic [1:0]       mode_sel;
  logic             amount_valid;
  logic [AMT_W-1:0] amount;
  logic [BAL_W-1:0] balance_in;
  logic             face_ok;
  logic             face_fail;
  logic             otp_ok;
  logic             otp_fail;
  logic             hw_done;
  logic             cancel;

  logic             dispense_cash;
  logic             deposit_cash;
  logic             print_receipt;
  logic             capture_face;
  logic             prompt_otp;
  logic             eject_card;
  logic             retain_card;
  logic [AMT_W-1:0] txn_amount;
  logic [7:0]       display_message;

  modport master (
    output card_inserted, card_valid, card_invalid, pin_valid, pin_invalid,
           mode_valid, mode_sel, amount_valid, amount, balance_in,
           face_ok, face_fail, otp_ok, otp_fail, hw_done, cancel,
    input  dispense_cash, deposit_cash, print_receipt, capture_face,
           prompt_otp, eject_card, retain_card, txn_amount, display_message
  );

  modport slave (
    input  card_inserted, card_valid, card_invalid, pin_valid, pin_invalid,
           mode_valid, mode_sel, amount_valid, amount, balance_in,
           face_ok, face_fail, otp_ok, otp_fail, hw_done, cancel,
    output dispense_cash, deposit_cash, print_receipt, capture_face,
           prompt_otp, eject_card, retain_card, txn_amount, display_message
  );
endinterface

// File: rtl/atm_session_fsm.sv
// ATM session controller: card scan, PIN with retry limit, mode/amount entry,
// face + optional OTP authentication, cash execution, receipt and card return.
module atm_session_fsm #(
  parameter int AMT_W         = 16,
  parameter int BAL_W         = 24,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 1000,
  parameter int OTP_THRESHOLD = 5000
) (
  input logic               clk,
  input logic               reset,
  atm_session_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, SCAN, PIN, MODE, AMOUNT, FACE, OTP, EXEC, RECEIPT, EJECT, RETAIN
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(MAX_PIN_TRIES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PIN_LAST   = PW'(MAX_PIN_TRIES - 1);
  localparam logic [31:0]   OTP_LIMIT  = 32'(OTP_THRESHOLD);

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_FUNDS   = 8'hE1;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE2;
  localparam logic [7:0] ERR_CARD    = 8'hE4;
  localparam logic [7:0] ERR_AUTH    = 8'hE5;
  localparam logic [7:0] ERR_CANCEL  = 8'hE6;

  localparam logic [1:0] MODE_WITHDRAW = 2'd0;
  localparam logic [1:0] MODE_DEPOSIT  = 2'd1;
  localparam logic [1:0] MODE_BALANCE  = 2'd2;

  state_t           state, stateNext;
  logic [TW-1:0]    timer, timerNext;
  logic [PW-1:0]    pinFailCnt, pinFailCntNext;
  logic [7:0]       errCode, errCodeNext;
  logic [AMT_W-1:0] txnAmount, txnAmountNext;
  logic [1:0]       modeReg, modeRegNext;
  logic             timedState;
  logic             strobe;
  logic             expired;

  function automatic logic [TW-1:0] timerInc(input logic [TW-1:0] t);
    return (t == {TW{1'b1}}) ? t : t + 1'b1;
  endfunction

  function automatic logic [PW-1:0] pinInc(input logic [PW-1:0] c);
    return (c == {PW{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [7:0] displayCode(input state_t s, input logic [7:0] err);
    case (s)
      IDLE:    return 8'h00;
      SCAN:    return 8'h01;
      PIN:     return 8'h02;
      MODE:    return 8'h03;
      AMOUNT:  return 8'h04;
      FACE:    return 8'h05;
      OTP:     return 8'h06;
      EXEC:    return 8'h07;
      RECEIPT: return 8'h08;
      EJECT:   return (err == ERR_NONE) ? 8'h09 : err;
      RETAIN:  return 8'hE3;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    stateNext      = state;
    errCodeNext    = errCode;
    pinFailCntNext = pinFailCnt;
    txnAmountNext  = txnAmount;
    modeRegNext    = modeReg;
    timedState     = (state inside {SCAN, PIN, MODE, AMOUNT, FACE, OTP});

    // Any strobe meaningful in the current state restarts its inactivity timer,
    // whether or not the strobe is acted upon.
    case (state)
      SCAN:    strobe = bus.card_valid | bus.card_invalid;
      PIN:     strobe = bus.pin_valid | bus.pin_invalid;
      MODE:    strobe = bus.mode_valid;
      AMOUNT:  strobe = bus.amount_valid;
      FACE:    strobe = bus.face_ok | bus.face_fail;
      OTP:     strobe = bus.otp_ok | bus.otp_fail;
      default: strobe = 1'b0;
    endcase
    expired = timedState && (timer >= TIMER_LAST);

    if (timedState && bus.cancel) begin
      stateNext   = EJECT;
      errCodeNext = ERR_CANCEL;
    end else if (expired) begin
      stateNext   = EJECT;
      errCodeNext = ERR_TIMEOUT;
    end else begin
      case (state)
        IDLE: if (bus.card_inserted) stateNext = SCAN;
        SCAN: begin
          if (bus.card_invalid) begin
            stateNext   = EJECT;
            errCodeNext = ERR_CARD;
          end else if (bus.card_valid) begin
            stateNext = PIN;
          end
        end
        PIN: begin
          if (bus.pin_invalid) begin
            pinFailCntNext = pinInc(pinFailCnt);
            if (pinFailCnt >= PIN_LAST) stateNext = RETAIN;
          end else if (bus.pin_valid) begin
            stateNext = MODE;
          end
        end
        MODE: begin
          if (bus.mode_valid) begin
            case (bus.mode_sel)
              MODE_WITHDRAW, MODE_DEPOSIT: begin
                stateNext   = AMOUNT;
                modeRegNext = bus.mode_sel;
              end
              MODE_BALANCE: begin
                stateNext   = RECEIPT;
                modeRegNext = MODE_BALANCE;
              end
              default: ;
            endcase
          end
        end
        AMOUNT: begin
          if (bus.amount_valid && (bus.amount != '0)) begin
            if ((modeReg == MODE_WITHDRAW) && (BAL_W'(bus.amount) > bus.balance_in)) begin
              stateNext   = EJECT;
              errCodeNext = ERR_FUNDS;
            end else begin
              txnAmountNext = bus.amount;
              stateNext     = (modeReg == MODE_WITHDRAW) ? FACE : EXEC;
            end
          end
        end
        FACE: begin
          if (bus.face_fail) begin
            stateNext   = EJECT;
            errCodeNext = ERR_AUTH;
          end else if (bus.face_ok) begin
            stateNext = (32'(txnAmount) >= OTP_LIMIT) ? OTP : EXEC;
          end
        end
        OTP: begin
          if (bus.otp_fail) begin
            stateNext   = EJECT;
            errCodeNext = ERR_AUTH;
          end else if (bus.otp_ok) begin
            stateNext = EXEC;
          end
        end
        EXEC:    if (bus.hw_done) stateNext = RECEIPT;
        RECEIPT: if (bus.hw_done) stateNext = EJECT;
        EJECT: begin
          if (!bus.card_inserted) begin
            stateNext      = IDLE;
            errCodeNext    = ERR_NONE;
            pinFailCntNext = '0;
            txnAmountNext  = '0;
            modeRegNext    = MODE_WITHDRAW;
          end
        end
        RETAIN: begin
          stateNext      = IDLE;
          errCodeNext    = ERR_NONE;
          pinFailCntNext = '0;
          txnAmountNext  = '0;
          modeRegNext    = MODE_WITHDRAW;
        end
        default: stateNext = IDLE;
      endcase
    end

    timerNext = (!timedState || (stateNext != state) || strobe) ? '0 : timerInc(timer);
  end

  // Outputs are decoded from the next state so they appear registered, one
  // cycle after the edge that samples the causing input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      timer               <= '0;
      pinFailCnt          <= '0;
      errCode             <= ERR_NONE;
      txnAmount           <= '0;
      modeReg             <= MODE_WITHDRAW;
      bus.dispense_cash   <= 1'b0;
      bus.deposit_cash    <= 1'b0;
      bus.print_receipt   <= 1'b0;
      bus.capture_face    <= 1'b0;
      bus.prompt_otp      <= 1'b0;
      bus.eject_card      <= 1'b0;
      bus.retain_card     <= 1'b0;
      bus.display_message <= 8'h00;
    end else begin
      state               <= stateNext;
      timer               <= timerNext;
      pinFailCnt          <= pinFailCntNext;
      errCode             <= errCodeNext;
      txnAmount           <= txnAmountNext;
      modeReg             <= modeRegNext;
      bus.dispense_cash   <= (stateNext == EXEC) && (modeRegNext == MODE_WITHDRAW);
      bus.deposit_cash    <= (stateNext == EXEC) && (modeRegNext == MODE_DEPOSIT);
      bus.print_receipt   <= (stateNext == RECEIPT);
      bus.capture_face    <= (stateNext == FACE);
      bus.prompt_otp      <= (stateNext == OTP);
      bus.eject_card      <= (stateNext == EJECT) && (state != EJECT);
      bus.retain_card     <= (stateNext == RETAIN) && (state != RETAIN);
      bus.display_message <= displayCode(stateNext, errCodeNext);
    end
  end

  assign bus.txn_amount = txnAmount;

endmodule
